dbg_controller: RTL and testbench
=================================

# dbg_controller

Debug-module-side controller for the processor debug interface. Accepts host debug commands (halt, resume, single-step, enter-debug, debug-register read/write) over a valid/ready command channel and sequences them onto a `DBG_IF.debug_module` port. Sits between the host transport bridge (JTAG/UART DTM) and the core. Returns one response per command, carrying read data or a status snapshot plus an error flag.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, 1024: maximum wait for any processor acknowledgement before the command is aborted with an error.
- `TO_W`, `$clog2(TIMEOUT_CYCLES+1)`: timeout counter width.

Ports:
- `clk`  in  1: single clock domain for the block.
- `nrst`  in  1: reset, asynchronous and active-low.
- `cmd_valid`  in  1: host command present.
- `cmd_ready`  out  1: controller accepts a command; high only in IDLE.
- `cmd_op`  in  3: `dbg_op_t` opcode.
- `cmd_addr`  in  8: debug register address for READ/WRITE.
- `cmd_wdata`  in  32: write data for WRITE.
- `rsp_valid`  out  1: response present.
- `rsp_ready`  in  1: host accepts the response.
- `rsp_data`  out  32: read data, or status `{29'b0, stalled, running, halted}`.
- `rsp_err`  out  1: timeout, or access attempted while not halted.
- `dbg`  modport  `DBG_IF.debug_module`: drives `enter_debug`, `req_halt`, `req_resume`, `step`, `dm_write`, `dm_addr`, `dm_wdata`; samples the other interface signals.

## Operation
- Opcodes:
  - 0 STATUS
  - 1 HALT
  - 2 RESUME
  - 3 STEP
  - 4 READ
  - 5 WRITE
  - 6 ENTER_DEBUG
  - 7 reserved, answered as STATUS with `rsp_err=1`.
- States: IDLE, ENTER, HALT_WAIT, RESUME_WAIT, STEP_PULSE, STEP_LEAVE, STEP_RETURN, ACCESS, RESP.
- IDLE:
  - A command is accepted on `cmd_valid && cmd_ready`, and op, addr and wdata are latched.
  - STATUS → RESP.
  - HALT → HALT_WAIT.
  - ENTER_DEBUG → ENTER.
  - RESUME → RESUME_WAIT.
  - STEP, READ, WRITE → RESP with `rsp_err=1` if `halted==0`. Otherwise STEP → STEP_PULSE, and READ/WRITE → ACCESS.
- ENTER: `enter_debug=1` for exactly one cycle, then HALT_WAIT.
- HALT_WAIT:
  - `req_halt=1` for as long as the state is held.
  - Exits to RESP on `halted==1`.
  - If already halted on entry, `req_halt` is high for one cycle and the exit follows immediately.
- RESUME_WAIT:
  - `req_resume=1` for as long as the state is held.
  - Exits to RESP on `running==1 && halted==0`.
- STEP sequence:
  - STEP_PULSE drives `step=1` for one cycle.
  - STEP_LEAVE waits for `halted==0`.
  - STEP_RETURN waits for `halted==1`, then RESP.
- ACCESS:
  - `dm_addr` and `dm_wdata` are held from the latched command.
  - `dm_write=1` for WRITE, 0 for READ.
  - Exits on `dm_access_valid==1`. On exit, `dm_rdata` is captured for READ; WRITE returns status.
  - `dm_write` drops the cycle after `dm_access_valid` is seen.
- Timeout:
  - The counter clears on entry to every wait state and increments each cycle while waiting.
  - When the count reaches `TIMEOUT_CYCLES`, all request outputs drop and the block goes to RESP with `rsp_err=1` and a status payload.
- RESP:
  - `rsp_valid=1`; `rsp_data` and `rsp_err` are stable until `rsp_ready`.
  - On `rsp_valid && rsp_ready`, return to IDLE.
  - Non-READ responses carry the status sampled in the cycle RESP is entered.
- Outside ACCESS: `dm_write=0`; `dm_addr` and `dm_wdata` hold their last value.

## Timing
- Reset values: all outputs 0, state IDLE, timeout counter 0.
  - Includes `cmd_ready` (it rises in the first cycle after reset release).
  - Includes `dm_addr` and `dm_wdata`.
- All outputs are registered.
- Command-to-request latency: the request output asserts in the cycle after acceptance.
- Acknowledge-to-response latency: `rsp_valid` asserts in the cycle after the acknowledging input is sampled.
- Minimum STATUS round trip: accept in cycle N, `rsp_valid` in N+1, `cmd_ready` in the cycle after the response handshake.
- No pipelining: at most one command is outstanding.
- A command is never accepted in the same cycle that a response completes.
- An acknowledge and a timeout in the same cycle: the acknowledge wins and `rsp_err=0`.
- `rsp_ready` held low: the block stalls in RESP indefinitely, with no timeout.
- `nrst` asserted mid-command: outputs clear asynchronously and the command is dropped without a response.

## Structure
- Shared package `dbg_pkg` holds:
  - `dbg_op_t` (3-bit enum)
  - `dbg_state_t`
  - status bit positions `DBG_ST_HALTED=0`, `DBG_ST_RUNNING=1`, `DBG_ST_STALLED=2`
  - default `DBG_TIMEOUT=1024`
- One sub-module, `dbg_timeout`: a clear/enable counter with an `expired` flag, parameterised by `TIMEOUT_CYCLES`. The FSM stays in `dbg_controller`.

## Test plan
1. Processor stub halts 5 cycles after `req_halt`; send HALT → `req_halt` high for 6 cycles, response `rsp_data=32'h1`, `rsp_err=0`.
2. Halted; WRITE addr `8'h04` data `32'hDEADBEEF`, stub acks after 3 cycles → `dm_addr=8'h04`, `dm_wdata=32'hDEADBEEF`, `dm_write` high until the ack; then READ addr `8'h04` → `rsp_data=32'hDEADBEEF`.
3. READ while running (`halted=0`) → no ACCESS state, `rsp_err=1`, `rsp_data=32'h2`.
4. Halted; STEP, stub drops `halted` for 4 cycles then re-asserts it → `step` is a single-cycle pulse, response `rsp_err=0` with status `32'h1`.
5. `TIMEOUT_CYCLES=16`; RESUME, stub never runs → `req_resume` high 16 cycles then low, `rsp_err=1`; hold `rsp_ready=0` for 10 cycles and check `rsp_valid` and `rsp_data` stay stable.
6. Pull `nrst` low while in HALT_WAIT → `req_halt=0` immediately and `rsp_valid=0`; after release, STATUS returns the current status with `rsp_err=0`.

Source files
------------

// File: rtl/dbg_pkg.sv
// dbg_pkg: opcode/state types, status bit layout and defaults shared by the debug controller files.
package dbg_pkg;
    typedef enum logic [2:0] {
        OP_STATUS, OP_HALT, OP_RESUME, OP_STEP, OP_READ, OP_WRITE, OP_ENTER_DEBUG, OP_RSVD
    } dbg_op_t;
    typedef enum logic [3:0] {
        S_IDLE, S_ENTER, S_HALT_WAIT, S_RESUME_WAIT, S_STEP_PULSE, S_STEP_LEAVE, S_STEP_RETURN, S_ACCESS, S_RESP
    } dbg_state_t;
    localparam int DBG_ST_HALTED  = 0;
    localparam int DBG_ST_RUNNING = 1;
    localparam int DBG_ST_STALLED = 2;
    localparam int DBG_TIMEOUT    = 1024;
    function automatic logic [31:0] dbg_status(input logic halted, input logic running, input logic stalled);
        logic [31:0] s;
        s = '0;
        s[DBG_ST_HALTED]  = halted;
        s[DBG_ST_RUNNING] = running;
        s[DBG_ST_STALLED] = stalled;
        return s;
    endfunction
endpackage

// File: rtl/dbg_controller_if.sv
// DBG_IF: debug port between the debug module (request side) and the core (status/ack side).
interface DBG_IF;
    logic        enter_debug, req_halt, req_resume, step, dm_write;
    logic [7:0]  dm_addr;
    logic [31:0] dm_wdata;
    logic        halted, running, stalled, dm_access_valid;
    logic [31:0] dm_rdata;
    modport debug_module (
        output enter_debug, req_halt, req_resume, step, dm_write, dm_addr, dm_wdata,
        input  halted, running, stalled, dm_access_valid, dm_rdata
    );
    modport core (
        input  enter_debug, req_halt, req_resume, step, dm_write, dm_addr, dm_wdata,
        output halted, running, stalled, dm_access_valid, dm_rdata
    );
endinterface

// File: rtl/dbg_timeout.sv
// dbg_timeout: clear/enable wait counter; expired_o flags the last allowed waiting cycle.
module dbg_timeout import dbg_pkg::*; #(
    parameter int TIMEOUT_CYCLES = DBG_TIMEOUT,
    parameter int TO_W = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic clk,
    input  logic nrst,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);
    logic [TO_W-1:0] cnt_q;
    // cnt_q counts completed waiting cycles, so the current one is number TIMEOUT_CYCLES at this value
    assign expired_o = cnt_q == TO_W'(TIMEOUT_CYCLES - 1);
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) cnt_q <= '0;
        else if (clr_i) cnt_q <= '0;
        else if (en_i && !expired_o) cnt_q <= cnt_q + 1'b1;
    end
endmodule

// File: rtl/dbg_controller.sv
// dbg_controller: sequences host debug commands onto the core debug port, one response per command.
module dbg_controller import dbg_pkg::*; #(
    parameter int TIMEOUT_CYCLES = DBG_TIMEOUT,
    parameter int TO_W = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  dbg_op_t     cmd_op,
    input  logic [7:0]  cmd_addr,
    input  logic [31:0] cmd_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic        rsp_err,
    DBG_IF.debug_module dbg
);
    dbg_state_t  state_q, state_d;
    dbg_op_t     op_q, op_d;
    logic        cmd_ready_q, cmd_ready_d, rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d;
    logic        enter_q, enter_d, halt_q, halt_d, resume_q, resume_d, step_q, step_d, write_q, write_d;
    logic [7:0]  addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d, data_q, data_d, status;
    logic        accept, waiting, ack, expired, op_bad, rsp_entry;

    assign accept    = cmd_valid && cmd_ready_q;
    assign op_d      = accept ? cmd_op : op_q;
    assign status    = dbg_status(dbg.halted, dbg.running, dbg.stalled);
    assign waiting   = state_q inside {S_HALT_WAIT, S_RESUME_WAIT, S_STEP_LEAVE, S_STEP_RETURN, S_ACCESS};
    assign ack       = (state_q == S_HALT_WAIT && dbg.halted) ||
                       (state_q == S_RESUME_WAIT && dbg.running && !dbg.halted) ||
                       (state_q == S_STEP_RETURN && dbg.halted) ||
                       (state_q == S_ACCESS && dbg.dm_access_valid);
    assign op_bad    = cmd_op == OP_RSVD || (cmd_op inside {OP_STEP, OP_READ, OP_WRITE} && !dbg.halted);
    assign rsp_entry = state_d == S_RESP && state_q != S_RESP;

    dbg_timeout #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES), .TO_W(TO_W)) u_timeout (
        .clk(clk), .nrst(nrst), .clr_i(state_d != state_q), .en_i(waiting), .expired_o(expired)
    );

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q     <= S_IDLE;
            op_q        <= OP_STATUS;
            cmd_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            data_q      <= '0;
            enter_q     <= 1'b0;
            halt_q      <= 1'b0;
            resume_q    <= 1'b0;
            step_q      <= 1'b0;
            write_q     <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            cmd_ready_q <= cmd_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            data_q      <= data_d;
            enter_q     <= enter_d;
            halt_q      <= halt_d;
            resume_q    <= resume_d;
            step_q      <= step_d;
            write_q     <= write_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
        end
    end

    // an acknowledge always beats an expiring timeout in the same cycle
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (accept)
                case (cmd_op)
                    OP_HALT:           state_d = S_HALT_WAIT;
                    OP_RESUME:         state_d = S_RESUME_WAIT;
                    OP_ENTER_DEBUG:    state_d = S_ENTER;
                    OP_STEP:           state_d = dbg.halted ? S_STEP_PULSE : S_RESP;
                    OP_READ, OP_WRITE: state_d = dbg.halted ? S_ACCESS : S_RESP;
                    default:           state_d = S_RESP;
                endcase
            S_ENTER:      state_d = S_HALT_WAIT;
            S_STEP_PULSE: state_d = S_STEP_LEAVE;
            S_STEP_LEAVE: state_d = !dbg.halted ? S_STEP_RETURN : expired ? S_RESP : S_STEP_LEAVE;
            S_HALT_WAIT, S_RESUME_WAIT, S_STEP_RETURN, S_ACCESS:
                          state_d = (ack || expired) ? S_RESP : state_q;
            S_RESP:       state_d = rsp_ready ? S_IDLE : S_RESP;
            default:      state_d = S_IDLE;
        endcase
    end

    // outputs are decoded from the next state so every port comes straight from a flop
    always_comb begin
        cmd_ready_d = state_d == S_IDLE;
        enter_d     = state_d == S_ENTER;
        halt_d      = state_d == S_HALT_WAIT;
        resume_d    = state_d == S_RESUME_WAIT;
        step_d      = state_d == S_STEP_PULSE;
        write_d     = state_d == S_ACCESS && op_d == OP_WRITE;
        addr_d      = (accept && state_d == S_ACCESS) ? cmd_addr : addr_q;
        wdata_d     = (accept && state_d == S_ACCESS) ? cmd_wdata : wdata_q;
        rsp_valid_d = state_d == S_RESP;
        data_d      = !rsp_entry ? data_q : (ack && state_q == S_ACCESS && op_q == OP_READ) ? dbg.dm_rdata : status;
        rsp_err_d   = !rsp_entry ? rsp_err_q : state_q == S_IDLE ? op_bad : !ack;
    end

    assign cmd_ready       = cmd_ready_q;
    assign rsp_valid       = rsp_valid_q;
    assign rsp_data        = data_q;
    assign rsp_err         = rsp_err_q;
    assign dbg.enter_debug = enter_q;
    assign dbg.req_halt    = halt_q;
    assign dbg.req_resume  = resume_q;
    assign dbg.step        = step_q;
    assign dbg.dm_write    = write_q;
    assign dbg.dm_addr     = addr_q;
    assign dbg.dm_wdata    = wdata_q;
endmodule

// File: tb/tb_dbg_controller.sv
// tb_dbg_controller: directed cycle-exact checks of the debug controller against a scripted core.
module tb_dbg_controller;
    import dbg_pkg::*;

    logic        clk = 1'b0;
    logic        nrst = 1'b0;
    logic        cmd_valid = 1'b0, rsp_ready = 1'b0;
    dbg_op_t     cmd_op = OP_STATUS;
    logic [7:0]  cmd_addr = '0;
    logic [31:0] cmd_wdata = '0;
    logic        cmd_ready, rsp_valid, rsp_err;
    logic [31:0] rsp_data;
    int          vectors = 0, miscompares = 0;

    always #5 clk = ~clk;

    DBG_IF dbg();

    dbg_controller #(.TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .nrst(nrst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .dbg(dbg)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_rsp(input string tag, input logic [31:0] data, input logic err);
        chk({tag, "_valid"}, rsp_valid, 1);
        chk({tag, "_data"}, rsp_data, data);
        chk({tag, "_err"}, rsp_err, err);
    endtask

    task automatic core(input logic h, input logic r);
        dbg.halted  = h;
        dbg.running = r;
    endtask

    // called on a negedge; returns on the negedge of the first cycle after acceptance
    task automatic send(input dbg_op_t op, input logic [7:0] a, input logic [31:0] d);
        int n = 0;
        while (!cmd_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("cmd_ready_wait", cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_addr  = a;
        cmd_wdata = d;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic finish_rsp();
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("rsp_done", rsp_valid, 0);
        chk("ready_back", cmd_ready, 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        core(1'b0, 1'b1);
        dbg.stalled = 1'b0;
        dbg.dm_access_valid = 1'b0;
        dbg.dm_rdata = '0;

        // reset state
        @(negedge clk);
        chk("rst_cmd_ready", cmd_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_data", rsp_data, 0);
        chk("rst_req_halt", dbg.req_halt, 0);
        chk("rst_dm_addr", dbg.dm_addr, 0);
        chk("rst_dm_wdata", dbg.dm_wdata, 0);
        nrst = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", cmd_ready, 1);

        // HALT: core halts late, req_halt high for 6 cycles
        send(OP_HALT, 8'h00, 32'h0);
        for (int i = 0; i < 6; i++) begin
            chk("halt_req_hi", dbg.req_halt, 1);
            if (i == 5) core(1'b1, 1'b0);
            @(negedge clk);
        end
        chk("halt_req_lo", dbg.req_halt, 0);
        chk("halt_busy", cmd_ready, 0);
        chk_rsp("halt", 32'h1, 1'b0);
        finish_rsp();

        // WRITE then READ back while halted
        send(OP_WRITE, 8'h04, 32'hDEADBEEF);
        chk("wr_addr", dbg.dm_addr, 32'h04);
        chk("wr_wdata", dbg.dm_wdata, 32'hDEADBEEF);
        for (int i = 0; i < 3; i++) begin
            chk("wr_write_hi", dbg.dm_write, 1);
            if (i == 2) dbg.dm_access_valid = 1'b1;
            else @(negedge clk);
        end
        @(negedge clk);
        dbg.dm_access_valid = 1'b0;
        chk("wr_write_lo", dbg.dm_write, 0);
        chk_rsp("wr", 32'h1, 1'b0);
        finish_rsp();
        send(OP_READ, 8'h04, 32'h0);
        chk("rd_write_lo", dbg.dm_write, 0);
        chk("rd_addr", dbg.dm_addr, 32'h04);
        dbg.dm_rdata = 32'hDEADBEEF;
        dbg.dm_access_valid = 1'b1;
        @(negedge clk);
        dbg.dm_access_valid = 1'b0;
        chk_rsp("rd", 32'hDEADBEEF, 1'b0);
        finish_rsp();

        // HALT while already halted: one-cycle request
        send(OP_HALT, 8'h00, 32'h0);
        chk("rehalt_req_hi", dbg.req_halt, 1);
        @(negedge clk);
        chk("rehalt_req_lo", dbg.req_halt, 0);
        chk_rsp("rehalt", 32'h1, 1'b0);
        finish_rsp();

        // STEP: core leaves halt for 4 sampled cycles
        send(OP_STEP, 8'h00, 32'h0);
        chk("step_hi", dbg.step, 1);
        core(1'b0, 1'b1);
        @(negedge clk);
        chk("step_lo", dbg.step, 0);
        @(negedge clk);
        @(negedge clk);
        chk("step_wait", rsp_valid, 0);
        @(negedge clk);
        chk("step_wait2", rsp_valid, 0);
        core(1'b1, 1'b0);
        @(negedge clk);
        chk_rsp("step", 32'h1, 1'b0);
        finish_rsp();

        // RESUME never acknowledged: times out after 16 cycles, response stalls
        send(OP_RESUME, 8'h00, 32'h0);
        n = 0;
        while (dbg.req_resume && n < 40) begin
            n++;
            @(negedge clk);
        end
        chk("resume_cycles", n, 16);
        chk_rsp("resume_to", 32'h1, 1'b1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk_rsp("resume_hold", 32'h1, 1'b1);
        end
        finish_rsp();

        // acknowledge in the expiry cycle wins over the timeout
        core(1'b0, 1'b1);
        send(OP_HALT, 8'h00, 32'h0);
        repeat (15) @(negedge clk);
        chk("race_req_hi", dbg.req_halt, 1);
        core(1'b1, 1'b0);
        @(negedge clk);
        chk_rsp("race", 32'h1, 1'b0);
        finish_rsp();

        // accesses while running are refused; reserved op answers status with error
        core(1'b0, 1'b1);
        send(OP_READ, 8'h10, 32'h0);
        chk("run_rd_write", dbg.dm_write, 0);
        chk("run_rd_addr", dbg.dm_addr, 32'h04);
        chk_rsp("run_rd", 32'h2, 1'b1);
        finish_rsp();
        send(OP_RSVD, 8'h00, 32'h0);
        chk_rsp("rsvd", 32'h2, 1'b1);
        finish_rsp();

        // ENTER_DEBUG: one-cycle enter pulse, then halt request
        send(OP_ENTER_DEBUG, 8'h00, 32'h0);
        chk("enter_hi", dbg.enter_debug, 1);
        chk("enter_nohalt", dbg.req_halt, 0);
        @(negedge clk);
        chk("enter_lo", dbg.enter_debug, 0);
        chk("enter_halt", dbg.req_halt, 1);
        core(1'b1, 1'b0);
        @(negedge clk);
        chk_rsp("enter", 32'h1, 1'b0);
        finish_rsp();

        // reset in HALT_WAIT drops the command; STATUS afterwards
        core(1'b0, 1'b1);
        send(OP_HALT, 8'h00, 32'h0);
        chk("mid_req_hi", dbg.req_halt, 1);
        #2 nrst = 1'b0;
        #1;
        chk("mid_rst_req", dbg.req_halt, 0);
        chk("mid_rst_valid", rsp_valid, 0);
        chk("mid_rst_ready", cmd_ready, 0);
        @(negedge clk);
        nrst = 1'b1;
        @(negedge clk);
        chk("mid_rel_ready", cmd_ready, 1);
        chk("mid_rel_valid", rsp_valid, 0);
        dbg.stalled = 1'b1;
        send(OP_STATUS, 8'h00, 32'h0);
        chk_rsp("status", 32'h6, 1'b0);
        finish_rsp();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
